// File: rtl/systolic_sequencer.sv
// Job controller for one MAC_WIDTH x MAC_WIDTH systolic tile: weight load, then feed/flush/drain per activation tile.
// Outputs are registered. Drain stalls on result_ready=0 with no timeout. `SYSTOLIC_SEQ_PERF_EN adds cycle/stall counters.
module systolic_sequencer #(
  parameter int DATA_SIZE    = 8,
  parameter int MAC_WIDTH    = 8,
  parameter int FLUSH_CYCLES = 2*MAC_WIDTH-1,
  parameter int TILE_W       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [TILE_W-1:0]            num_tiles,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         weight_load_en,
  output logic [$clog2(MAC_WIDTH)-1:0] weight_row,
  output logic                         feed_en,
  output logic [$clog2(MAC_WIDTH)-1:0] feed_row,
  output logic                         setup_clear,
  output logic                         acc_clear,
  output logic                         result_valid,
  output logic [$clog2(MAC_WIDTH)-1:0] result_row,
  output logic [TILE_W-1:0]            tile_idx
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stalls
`endif
);

  localparam int CNT_MAX = (FLUSH_CYCLES > MAC_WIDTH) ? FLUSH_CYCLES : MAC_WIDTH;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int RW      = $clog2(MAC_WIDTH);
  localparam logic [CW-1:0] ROW_LAST   = CW'(MAC_WIDTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

  if (DATA_SIZE < 1 || MAC_WIDTH < 2 || FLUSH_CYCLES < 1) begin : g_bad_params
    $error("systolic_sequencer: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DRAIN, DONE} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [TILE_W-1:0] tiles_lat, tiles_d, tile_d;
  logic              setup_clear_d, acc_clear_d;

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    tile_d        = tile_idx;
    tiles_d       = tiles_lat;
    setup_clear_d = 1'b0;
    acc_clear_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (num_tiles != '0) begin
            tiles_d       = num_tiles;
            state_d       = LOAD;
            setup_clear_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (cnt == ROW_LAST) begin
          state_d     = FEED;
          cnt_d       = '0;
          acc_clear_d = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      FEED: begin
        if (cnt == ROW_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DRAIN: begin
        if (result_ready) begin
          if (cnt == ROW_LAST) begin
            cnt_d = '0;
            if (tile_idx == tiles_lat - TILE_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d     = FEED;
              tile_d      = tile_idx + TILE_W'(1);
              acc_clear_d = 1'b1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        tile_d  = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tile_d  = '0;
      end
    endcase
    // Abort outranks every phase transition and scrubs the datapath on the way out.
    if (abort && state != IDLE) begin
      state_d       = IDLE;
      cnt_d         = '0;
      tile_d        = '0;
      setup_clear_d = 1'b1;
      acc_clear_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      tiles_lat      <= '0;
      tile_idx       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      weight_load_en <= 1'b0;
      weight_row     <= '0;
      feed_en        <= 1'b0;
      feed_row       <= '0;
      setup_clear    <= 1'b0;
      acc_clear      <= 1'b0;
      result_valid   <= 1'b0;
      result_row     <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      tiles_lat      <= tiles_d;
      tile_idx       <= tile_d;
      busy           <= (state_d != IDLE);
      done           <= (state_d == DONE);
      weight_load_en <= (state_d == LOAD);
      weight_row     <= (state_d == LOAD) ? cnt_d[RW-1:0] : '0;
      feed_en        <= (state_d == FEED);
      feed_row       <= (state_d == FEED) ? cnt_d[RW-1:0] : '0;
      setup_clear    <= setup_clear_d;
      acc_clear      <= acc_clear_d;
      result_valid   <= (state_d == DRAIN);
      result_row     <= (state_d == DRAIN) ? cnt_d[RW-1:0] : '0;
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == DRAIN && !result_ready)
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer at MAC_WIDTH=8, FLUSH_CYCLES=15; cycle n is the n-th cycle after the start edge.
module tb_systolic_sequencer;

  logic       clock, reset, start, abort, result_ready;
  logic [7:0] num_tiles;
  logic       busy, done, weight_load_en, feed_en, setup_clear, acc_clear, result_valid;
  logic [2:0] weight_row, feed_row, result_row;
  logic [7:0] tile_idx;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  systolic_sequencer #(.DATA_SIZE(8), .MAC_WIDTH(8), .FLUSH_CYCLES(15), .TILE_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_tiles(num_tiles), .result_ready(result_ready),
    .busy(busy), .done(done),
    .weight_load_en(weight_load_en), .weight_row(weight_row),
    .feed_en(feed_en), .feed_row(feed_row),
    .setup_clear(setup_clear), .acc_clear(acc_clear),
    .result_valid(result_valid), .result_row(result_row),
    .tile_idx(tile_idx)
`ifdef SYSTOLIC_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // {busy, done, weight_load_en, feed_en, result_valid, setup_clear, acc_clear}
  function automatic logic [6:0] flags();
    return {busy, done, weight_load_en, feed_en, result_valid, setup_clear, acc_clear};
  endfunction

  function automatic logic [6:0] exp_single(input int c);
    return {c <= 40, c == 40, c >= 1 && c <= 8, c >= 9 && c <= 16, c >= 32 && c <= 39, c == 1, c == 9};
  endfunction

  task automatic launch(input int n);
    num_tiles = 8'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int nw, nf, nd, dcyc, any_en;
    int ac_q[$];
    int exp_ac[3] = '{9, 40, 71};

    reset = 1'b1; start = 1'b0; abort = 1'b0; num_tiles = '0; result_ready = 1'b1;
    #2;
    chk("reset_flags", 32'(flags()), 0);
    chk("reset_rows", {weight_row, feed_row, result_row}, 0);
    chk("reset_tile", tile_idx, 0);
    #10 reset = 1'b0;
    step();

    // Single tile, no backpressure
    launch(1);
    for (int c = 1; c <= 41; c++) begin
      if (c > 1) step();
      chk($sformatf("t1_flags_c%0d", c), 32'(flags()), 32'(exp_single(c)));
      if (c >= 1 && c <= 8)   chk($sformatf("t1_wrow_c%0d", c), weight_row, c - 1);
      if (c >= 9 && c <= 16)  chk($sformatf("t1_frow_c%0d", c), feed_row, c - 9);
      if (c >= 32 && c <= 39) chk($sformatf("t1_rrow_c%0d", c), result_row, c - 32);
    end

    // Three tiles sharing one weight load
    launch(3);
    nw = 0; nf = 0; nd = 0; dcyc = -1;
    for (int c = 1; c <= 103; c++) begin
      if (c > 1) step();
      nw += int'(weight_load_en);
      nf += int'(feed_en);
      if (acc_clear) ac_q.push_back(c);
      if (done) begin nd++; dcyc = c; end
      if (c == 9)  chk("t3_tile_c9", tile_idx, 0);
      if (c == 40) chk("t3_tile_c40", tile_idx, 1);
      if (c == 71) chk("t3_tile_c71", tile_idx, 2);
      if (c == 103) chk("t3_idle_c103", {busy, tile_idx}, 0);
    end
    chk("t3_wload_cycles", nw, 8);
    chk("t3_feed_cycles", nf, 24);
    chk("t3_acc_clear_count", ac_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t3_acc_clear_%0d", i), (i < ac_q.size()) ? ac_q[i] : -1, exp_ac[i]);
    chk("t3_done_cycle", dcyc, 102);
    chk("t3_done_count", nd, 1);

    // Backpressure: ready low for cycles 34..38 (third drain beat)
    launch(1);
    dcyc = -1;
    for (int c = 1; c <= 46; c++) begin
      if (c > 1) step();
      if (c >= 34 && c <= 38) begin
        chk($sformatf("bp_rrow_c%0d", c), result_row, 2);
        chk($sformatf("bp_rvld_c%0d", c), result_valid, 1);
      end
      if (c == 40) chk("bp_rrow_c40", result_row, 3);
      if (done) dcyc = c;
      result_ready = !(c >= 34 && c <= 38);
    end
    result_ready = 1'b1;
    chk("bp_done_cycle", dcyc, 45);
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk("bp_perf_stalls", perf_stalls, 5);
    chk("bp_perf_cycles", perf_cycles, 45);
`endif

    // Abort in FLUSH
    launch(2);
    for (int c = 2; c <= 20; c++) step();
    chk("ab_flush_c20", 32'(flags()), 32'(7'b1000000));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_c21_flags", 32'(flags()), 32'(7'b0000011));
    chk("ab_c21_tile", tile_idx, 0);
    nd = 0;
    for (int c = 22; c <= 26; c++) begin
      step();
      nd += int'(done) + int'(busy) + int'(setup_clear) + int'(acc_clear);
    end
    chk("ab_quiet_after", nd, 0);

    // Abort alone in IDLE is inert
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort", 32'(flags()), 0);

    // Start with abort in IDLE: start wins, job runs normally
    num_tiles = 8'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_c1_flags", 32'(flags()), 32'(7'b1010010));
    dcyc = -1;
    for (int c = 2; c <= 41; c++) begin
      step();
      if (done) dcyc = c;
    end
    chk("sa_done_cycle", dcyc, 40);

    // Zero tiles
    launch(0);
    chk("z_c1_flags", 32'(flags()), 32'(7'b1100000));
    any_en = 0;
    for (int c = 2; c <= 5; c++) begin
      step();
      any_en += int'(weight_load_en) + int'(feed_en) + int'(result_valid) + int'(done) + int'(busy);
    end
    chk("z_no_activity", any_en, 0);

    // Start while busy is ignored, then async reset mid-FEED
    launch(1);
    step(); step();
    num_tiles = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_c4", {busy, done, weight_load_en, 5'(weight_row)}, {1'b1, 1'b0, 1'b1, 5'd3});
    for (int c = 5; c <= 12; c++) step();
    chk("rst_pre_feed", {feed_en, 5'(feed_row)}, {1'b1, 5'd3});
    #3 reset = 1'b1;
    #1;
    chk("rst_async_flags", 32'(flags()), 0);
    chk("rst_async_rows", {weight_row, feed_row, result_row, tile_idx}, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk("rst_async_perf", perf_cycles | perf_stalls, 0);
`endif
    #2 reset = 1'b0;
    step();
    chk("rst_after_edge", 32'(flags()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Top-level job controller for one MAC_WIDTH x MAC_WIDTH systolic tile engine.
- Sequences the engine through weight load, activation feed into the left-edge skew/FIFO setup stage, pipeline flush and result drain.
- Repeats the feed, flush and drain phases for a programmable number of activation tiles that share one weight set.
- Sits between the host command interface and the setup/array/accumulator blocks, and drives only their enables, row selects and clears.

Parameters:
- DATA_SIZE, 8, element width in bits; unused internally, kept for consistency.
- MAC_WIDTH, 8, array dimension. Sets the LOAD, FEED and DRAIN phase lengths.
- FLUSH_CYCLES, 2*MAC_WIDTH-1, number of idle cycles for zeros to clear the skew stage and the array depth.
- TILE_W, 8, width of the tile count.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- start  input  1  job start pulse; sampled only in IDLE
- abort  input  1  job abort; honoured in any non-IDLE state
- num_tiles  input  TILE_W  activation tiles per job; latched on an accepted start
- result_ready  input  1  downstream accepts a result row
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on job completion
- weight_load_en  output  1  write current weight row into the array
- weight_row  output  $clog2(MAC_WIDTH)  weight row index
- feed_en  output  1  setup stage accepts activation row feed_row
- feed_row  output  $clog2(MAC_WIDTH)  activation row index
- setup_clear  output  1  one-cycle clear of the skew FIFOs
- acc_clear  output  1  one-cycle clear of the array accumulators
- result_valid  output  1  result row result_row is presented
- result_row  output  $clog2(MAC_WIDTH)  result row index
- tile_idx  output  TILE_W  index of the tile currently in process

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE;
  - all outputs, counters and the latched tile count to 0.
- States are IDLE, LOAD, FEED, FLUSH, DRAIN, DONE. A single phase counter cnt is cleared on every state entry.
- IDLE:
  - start=1 with num_tiles!=0: latch num_tiles, go to LOAD, pulse setup_clear in the first LOAD cycle.
  - start=1 with num_tiles==0: go directly to DONE.
- LOAD, MAC_WIDTH cycles:
  - weight_load_en=1, weight_row=cnt.
  - After cnt==MAC_WIDTH-1, go to FEED.
- FEED, MAC_WIDTH cycles:
  - feed_en=1, feed_row=cnt.
  - acc_clear=1 in the first cycle only.
  - After the last row, go to FLUSH.
- FLUSH, FLUSH_CYCLES cycles:
  - all enables 0.
  - Then go to DRAIN.
- DRAIN, MAC_WIDTH beats:
  - result_valid=1, result_row=cnt.
  - cnt advances only on result_valid&&result_ready. result_row holds stable while result_ready=0; no timeout.
  - On the last accepted beat:
    - if tile_idx==latched_tiles-1, go to DONE;
    - otherwise increment tile_idx and go to FEED (weights are not reloaded).
- DONE:
  - done=1 for exactly one cycle.
  - Return to IDLE with tile_idx cleared.
- All outputs are registered; each takes its state-dependent value in the same cycle the state register holds that state.
- start while busy: ignored; no queuing.
- abort:
  - From any non-IDLE state: next state IDLE, setup_clear=1 and acc_clear=1 for one cycle, done not asserted.
  - abort has priority over every phase transition.
  - abort in IDLE has no effect.
- start and abort together in IDLE: start wins. An abort in IDLE is meaningless, so the job is accepted.
- Reset mid-job: the job is lost; no done pulse.
- Counter wrap: cnt is sized to max(FLUSH_CYCLES, MAC_WIDTH) and never exceeds the current phase length. tile_idx never exceeds latched_tiles-1.

Optional Feature:
- Macro: SYSTOLIC_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles (32 bits) and perf_stalls (32 bits).
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts DRAIN cycles with result_ready=0.
  - Both clear on an accepted start and hold their value after done. Reset clears both.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single tile: MAC_WIDTH=8, FLUSH_CYCLES=15, num_tiles=1, result_ready=1, start sampled at edge 0.
  - LOAD cycles 1-8 (weight_row 0..7), FEED 9-16, FLUSH 17-31, DRAIN 32-39 (result_row 0..7).
  - done=1 in cycle 40 only; busy=0 from cycle 41.
  - setup_clear high in cycle 1 only; acc_clear high in cycle 9 only.
- Three tiles: num_tiles=3.
  - Exactly 8 weight_load_en cycles and 24 feed_en cycles; tile_idx steps 0,1,2.
  - acc_clear high in cycles 9, 40 and 71; done in cycle 102.
- Backpressure: result_ready=0 for 5 cycles at the third DRAIN beat.
  - result_row holds at 2, done is delayed by 5 cycles, perf_stalls=5 when SYSTOLIC_SEQ_PERF_EN is defined.
- Abort in FLUSH at cycle 20.
  - Cycle 21: IDLE with setup_clear=acc_clear=1; no done.
  - A new start is then accepted normally.
- num_tiles=0: start produces done in cycle 1; no weight_load_en, feed_en or result_valid ever asserted.
- Async reset asserted mid-FEED between clock edges.
  - All outputs 0 immediately, without waiting for an edge; state IDLE.
  - A start while busy has no effect.
